sample_rle_stream: RTL and testbench

Parametrised run-length encoder for captured sample words. It sits between the sample mux/strober and the capture transport. Unlike the fixed 16-bit compressor, it:
- accepts a sample on every clock, with no idle cycle required between strobes;
- buffers its encoded output in an internal FIFO behind a valid/ready interface;
- supports an explicit flush of a pending run.

Overflow is reported through a sticky, software-clearable flag.

---
 rtl/sample_rle_stream.sv | 240 ++++++++++++++++++++++++
 tb/tb_sample_rle_stream.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sample_rle_stream.sv
// sample_rle_stream
// -----------------
// Run-length encoder for captured sample words. It accepts one sample per
// clock and never stalls the producer. Encoded words go into an internal
// first-word-fall-through FIFO that is read through a valid/ready port.
//
// Encoded stream, as seen by the decoder:
//   - Distinct samples are passed through unchanged.
//   - Two equal consecutive data words are always followed by count words:
//     zero or more all-ones words (each worth 2^W-1 extra repeats), then one
//     terminating count word with a value of 0..2^W-2.
//
// Ports
//   clk, rst_n      clock; asynchronous active-low reset
//   in_data [W]     sample word, qualified by in_valid
//   in_valid        sample strobe; legal every cycle, never stalled
//   flush           terminates a pending run; acts after the same-cycle sample
//   out_data [W]    FIFO head word (0 while the FIFO is empty)
//   out_valid       FIFO non-empty
//   out_ready       consumer takes the head when out_valid & out_ready
//   level           FIFO occupancy in words
//   overflow        sticky; set when encoded words had to be dropped
//   overflow_clr    clears overflow at the next edge; a same-cycle set wins
//   dbg_state [2]   encoder state (0 st_init, 1 st_single, 2 st_run)
//
// Handshake: a word leaves the FIFO on a rising edge where out_valid and
// out_ready are both high; out_data holds steady while out_valid is high and
// out_ready is low. The input side has no back-pressure, so when the FIFO
// lacks space for a cycle's words they are dropped and overflow is raised.

module sample_rle_stream #(
  parameter int W     = 16,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [W-1:0]             in_data,
  input  logic                     in_valid,
  input  logic                     flush,
  output logic [W-1:0]             out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  input  logic                     overflow_clr,
  output logic [1:0]               dbg_state
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);
  // Largest count a terminating count word can carry (2^W-2).
  localparam logic [W-1:0]  CNT_MAX = {{(W-1){1'b1}}, 1'b0};

  typedef enum logic [1:0] {
    st_init   = 2'd0,
    st_single = 2'd1,
    st_run    = 2'd2
  } state_e;

  // ---------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------
  state_e          state_q, state_d;
  logic [W-1:0]    cnt_q, cnt_d;
  logic [W-1:0]    last_q, last_d;
  logic            overflow_q, overflow_d;

  logic [W-1:0]    mem_q [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]   level_q, level_d;

  // Encoder results for this cycle.
  logic [1:0]      n_words;     // words produced (0..2)
  logic [W-1:0]    word0;       // first emitted word
  logic [W-1:0]    word1;       // second emitted word
  state_e          s_post;      // state after the sample, before flush
  logic [W-1:0]    c_post;      // count after the sample, before flush
  state_e          s_final;     // state after flush
  logic [W-1:0]    c_final;     // count after flush
  logic [LW-1:0]   free_words;
  logic            drop;        // this cycle's words do not fit
  logic [1:0]      push_n;      // words actually written to the FIFO
  logic            pop;

  // ---------------------------------------------------------------------
  // Encoder next state
  // ---------------------------------------------------------------------
  always_comb begin
    n_words = 2'd0;
    word0   = '0;
    word1   = '0;
    s_post  = state_q;
    c_post  = cnt_q;
    last_d  = last_q;

    if (in_valid) begin
      last_d = in_data;
      case (state_q)
        st_init: begin
          word0   = in_data;
          n_words = 2'd1;
          s_post  = st_single;
        end
        st_single: begin
          word0   = in_data;
          n_words = 2'd1;
          if (in_data == last_q) begin
            s_post = st_run;
            c_post = '0;
          end
        end
        st_run: begin
          if (in_data == last_q) begin
            if (cnt_q == CNT_MAX) begin
              // Saturated: all-ones stands for 2^W-1 repeats, run continues.
              word0   = '1;
              n_words = 2'd1;
              c_post  = '0;
            end else begin
              c_post = cnt_q + W'(1);
            end
          end else begin
            word0   = cnt_q;
            word1   = in_data;
            n_words = 2'd2;
            s_post  = st_single;
          end
        end
        default: begin
          s_post = st_init;
          c_post = '0;
        end
      endcase
    end
  end

  // Flush acts on the post-sample state. A run can only be pending here with
  // zero or one word already produced, so the total never exceeds two.
  always_comb begin
    s_final = s_post;
    c_final = c_post;
    if (flush) begin
      case (s_post)
        st_run: begin
          s_final = st_init;
          c_final = '0;
        end
        st_single: s_final = st_init;
        default:   s_final = s_post;
      endcase
    end
  end

  logic [1:0]   n_total;
  logic [W-1:0] wr_word0;
  logic [W-1:0] wr_word1;

  always_comb begin
    n_total  = n_words;
    wr_word0 = word0;
    wr_word1 = word1;
    if (flush && (s_post == st_run)) begin
      if (n_words == 2'd0) begin
        wr_word0 = c_post;
      end else begin
        wr_word1 = c_post;
      end
      n_total = n_words + 2'd1;
    end
  end

  // ---------------------------------------------------------------------
  // Space check and FIFO bookkeeping
  // ---------------------------------------------------------------------
  // Free space is taken at cycle start; a same-cycle pop is not credited.
  assign free_words = DEPTH_L - level_q;
  assign drop       = (LW'(n_total) > free_words);
  assign pop        = out_valid & out_ready;

  always_comb begin
    push_n     = drop ? 2'd0 : n_total;
    // On a drop the decoder loses track of the run, so restart from
    // st_init: the next sample then goes out raw and resynchronises it.
    state_d    = drop ? st_init : s_final;
    cnt_d      = drop ? '0 : c_final;
    overflow_d = overflow_q;
    if (overflow_clr) begin
      overflow_d = 1'b0;
    end
    if (drop) begin
      overflow_d = 1'b1;
    end
    wr_ptr_d   = wr_ptr_q + PW'(push_n);
    rd_ptr_d   = rd_ptr_q + PW'(pop);
    level_d    = level_q + LW'(push_n) - LW'(pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= st_init;
      cnt_q      <= '0;
      last_q     <= '0;
      overflow_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      last_q     <= last_d;
      overflow_q <= overflow_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
    end
  end

  // Storage needs no reset: out_data is masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push_n != 2'd0) begin
      mem_q[wr_ptr_q] <= wr_word0;
    end
    if (push_n == 2'd2) begin
      mem_q[wr_ptr_q + PW'(1)] <= wr_word1;
    end
  end

  // ---------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------
  assign out_valid = (level_q != '0);
  assign out_data  = out_valid ? mem_q[rd_ptr_q] : '0;
  assign level     = level_q;
  assign overflow  = overflow_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_sample_rle_stream.sv
// Directed bench for sample_rle_stream. Instance "a" is W=16/DEPTH=16,
// instance "b" is W=8/DEPTH=4. Inputs change 1 time unit after the rising
// edge; outputs are read at the falling edge or just after the drive step.

module tb_sample_rle_stream;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  // ---------------- instance a (W=16, DEPTH=16) ----------------
  logic [15:0] a_data;
  logic        a_valid, a_flush, a_ready, a_clr;
  logic [15:0] a_out;
  logic        a_ovalid, a_ovf;
  logic [4:0]  a_level;
  logic [1:0]  a_state;

  sample_rle_stream #(.W(16), .DEPTH(16)) u_a (
    .clk(clk), .rst_n(rst_n),
    .in_data(a_data), .in_valid(a_valid), .flush(a_flush),
    .out_data(a_out), .out_valid(a_ovalid), .out_ready(a_ready),
    .level(a_level), .overflow(a_ovf), .overflow_clr(a_clr),
    .dbg_state(a_state)
  );

  // ---------------- instance b (W=8, DEPTH=4) ----------------
  logic [7:0]  b_data;
  logic        b_valid, b_flush, b_ready, b_clr;
  logic [7:0]  b_out;
  logic        b_ovalid, b_ovf;
  logic [2:0]  b_level;
  logic [1:0]  b_state;

  sample_rle_stream #(.W(8), .DEPTH(4)) u_b (
    .clk(clk), .rst_n(rst_n),
    .in_data(b_data), .in_valid(b_valid), .flush(b_flush),
    .out_data(b_out), .out_valid(b_ovalid), .out_ready(b_ready),
    .level(b_level), .overflow(b_ovf), .overflow_clr(b_clr),
    .dbg_state(b_state)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [15:0] exp_a_q[$];
  logic [7:0]  exp_b_q[$];
  logic [15:0] mon_a_exp;
  logic [7:0]  mon_b_exp;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Every word accepted by the consumer is compared with the expected queue.
  always @(negedge clk) begin
    if (rst_n && a_ovalid && a_ready) begin
      if (exp_a_q.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL a_extra observed=%0h expected=none", a_out);
      end else begin
        mon_a_exp = exp_a_q.pop_front();
        check("a_stream", 32'(a_out), 32'(mon_a_exp));
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && b_ovalid && b_ready) begin
      if (exp_b_q.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL b_extra observed=%0h expected=none", b_out);
      end else begin
        mon_b_exp = exp_b_q.pop_front();
        check("b_stream", 32'(b_out), 32'(mon_b_exp));
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called 1 unit after a rising edge; returns 1 unit after the next one.
  task automatic drive_a(input logic v, input logic [15:0] d, input logic f, input logic c);
    a_valid = v; a_data = d; a_flush = f; a_clr = c;
    @(posedge clk); #1;
    a_valid = 1'b0; a_flush = 1'b0; a_clr = 1'b0;
  endtask

  task automatic drive_b(input logic v, input logic [7:0] d, input logic f, input logic c);
    b_valid = v; b_data = d; b_flush = f; b_clr = c;
    @(posedge clk); #1;
    b_valid = 1'b0; b_flush = 1'b0; b_clr = 1'b0;
  endtask

  task automatic idle_a(input int n);
    for (int i = 0; i < n; i++) drive_a(1'b0, 16'h0, 1'b0, 1'b0);
  endtask

  task automatic idle_b(input int n);
    for (int i = 0; i < n; i++) drive_b(1'b0, 8'h0, 1'b0, 1'b0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "bench did not finish");
  end

  // ---------------- directed sequence ----------------
  initial begin
    rst_n = 1'b0;
    a_data = '0; a_valid = 1'b0; a_flush = 1'b0; a_ready = 1'b1; a_clr = 1'b0;
    b_data = '0; b_valid = 1'b0; b_flush = 1'b0; b_ready = 1'b1; b_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Reset state
    check("rst_valid", 32'(a_ovalid), 32'd0);
    check("rst_data",  32'(a_out),    32'd0);
    check("rst_level", 32'(a_level),  32'd0);
    check("rst_ovf",   32'(a_ovf),    32'd0);
    check("rst_state", 32'(a_state),  32'd0);
    rst_n = 1'b1;

    // Distinct samples: one word per cycle, head one cycle after the strobe
    exp_a_q.push_back(16'h1111);
    exp_a_q.push_back(16'h2222);
    exp_a_q.push_back(16'h3333);
    drive_a(1'b1, 16'h1111, 1'b0, 1'b0);
    check("dist_valid0", 32'(a_ovalid), 32'd1);
    check("dist_data0",  32'(a_out),    32'h1111);
    drive_a(1'b1, 16'h2222, 1'b0, 1'b0);
    check("dist_data1",  32'(a_out),    32'h2222);
    drive_a(1'b1, 16'h3333, 1'b0, 1'b0);
    check("dist_data2",  32'(a_out),    32'h3333);
    check("dist_level",  32'(a_level),  32'd1);
    idle_a(1);
    check("dist_empty",  32'(a_ovalid), 32'd0);

    // Basic run A,A,A,A,B held in the FIFO: A, A, 0002, B
    a_ready = 1'b0;
    exp_a_q.push_back(16'hAAAA);
    exp_a_q.push_back(16'hAAAA);
    exp_a_q.push_back(16'h0002);
    exp_a_q.push_back(16'hBBBB);
    drive_a(1'b1, 16'hAAAA, 1'b0, 1'b0);
    drive_a(1'b1, 16'hAAAA, 1'b0, 1'b0);
    check("run_state_run", 32'(a_state), 32'd2);
    check("run_level2",    32'(a_level), 32'd2);
    drive_a(1'b1, 16'hAAAA, 1'b0, 1'b0);
    drive_a(1'b1, 16'hAAAA, 1'b0, 1'b0);
    check("run_level_hold", 32'(a_level), 32'd2);
    drive_a(1'b1, 16'hBBBB, 1'b0, 1'b0);
    check("run_level_peak", 32'(a_level), 32'd4);
    check("run_state_single", 32'(a_state), 32'd1);
    check("run_ovf", 32'(a_ovf), 32'd0);
    check("run_head", 32'(a_out), 32'hAAAA);
    a_ready = 1'b1;
    idle_a(4);
    check("run_drained", 32'(a_level), 32'd0);

    // Flush with the third A: F0, F0, 0001
    exp_a_q.push_back(16'h00F0);
    exp_a_q.push_back(16'h00F0);
    exp_a_q.push_back(16'h0001);
    exp_a_q.push_back(16'h00F0);
    drive_a(1'b1, 16'h00F0, 1'b0, 1'b0);
    drive_a(1'b1, 16'h00F0, 1'b0, 1'b0);
    drive_a(1'b1, 16'h00F0, 1'b1, 1'b0);
    check("fl_state_init", 32'(a_state), 32'd0);
    check("fl_count",      32'(a_out),   32'h0001);
    // Subsequent equal sample is emitted fresh
    drive_a(1'b1, 16'h00F0, 1'b0, 1'b0);
    check("fl_fresh_state", 32'(a_state), 32'd1);
    check("fl_fresh_data",  32'(a_out),   32'h00F0);
    // Flush from st_single produces nothing
    drive_a(1'b0, 16'h0, 1'b1, 1'b0);
    check("fl_single_state", 32'(a_state), 32'd0);
    check("fl_single_level", 32'(a_level), 32'd0);

    // Flush together with a change sample in st_run: A, A, 0000, B
    exp_a_q.push_back(16'h1234);
    exp_a_q.push_back(16'h1234);
    exp_a_q.push_back(16'h0000);
    exp_a_q.push_back(16'h5678);
    drive_a(1'b1, 16'h1234, 1'b0, 1'b0);
    drive_a(1'b1, 16'h1234, 1'b0, 1'b0);
    drive_a(1'b1, 16'h5678, 1'b1, 1'b0);
    check("flc_level", 32'(a_level), 32'd2);
    check("flc_head",  32'(a_out),   32'h0000);
    check("flc_state", 32'(a_state), 32'd0);
    idle_a(2);

    // Counter wrap on W=8: 257 x 5A then B0 -> 5A, 5A, FF, 00, B0
    exp_b_q.push_back(8'h5A);
    exp_b_q.push_back(8'h5A);
    exp_b_q.push_back(8'hFF);
    exp_b_q.push_back(8'h00);
    exp_b_q.push_back(8'hB0);
    for (int i = 0; i < 257; i++) drive_b(1'b1, 8'h5A, 1'b0, 1'b0);
    check("wrap_ff",    32'(b_out),   32'hFF);
    check("wrap_level", 32'(b_level), 32'd1);
    check("wrap_state", 32'(b_state), 32'd2);
    drive_b(1'b1, 8'hB0, 1'b0, 1'b0);
    check("wrap_zero",   32'(b_out),   32'h00);
    check("wrap_level2", 32'(b_level), 32'd2);
    idle_b(2);
    check("wrap_drained", 32'(b_level), 32'd0);

    // Overflow on DEPTH=4: fifth distinct sample is dropped
    b_ready = 1'b0;
    for (int i = 1; i <= 4; i++) exp_b_q.push_back(8'(i));
    for (int i = 1; i <= 5; i++) drive_b(1'b1, 8'(i), 1'b0, 1'b0);
    check("ovf_level", 32'(b_level),  32'd4);
    check("ovf_flag",  32'(b_ovf),    32'd1);
    check("ovf_valid", 32'(b_ovalid), 32'd1);
    check("ovf_state", 32'(b_state),  32'd0);
    check("ovf_head",  32'(b_out),    32'h01);
    b_ready = 1'b1;
    idle_b(4);
    check("ovf_drained", 32'(b_level), 32'd0);
    check("ovf_sticky",  32'(b_ovf),   32'd1);
    drive_b(1'b0, 8'h0, 1'b0, 1'b1);
    check("ovf_cleared", 32'(b_ovf), 32'd0);

    // Overflow with simultaneous clear: set wins
    b_ready = 1'b0;
    for (int i = 6; i <= 9; i++) exp_b_q.push_back(8'(i));
    for (int i = 6; i <= 9; i++) drive_b(1'b1, 8'(i), 1'b0, 1'b0);
    check("ovf2_noflag", 32'(b_ovf), 32'd0);
    drive_b(1'b1, 8'h0A, 1'b0, 1'b1);
    check("ovf2_setwins", 32'(b_ovf),   32'd1);
    check("ovf2_level",   32'(b_level), 32'd4);
    b_ready = 1'b1;
    idle_b(4);
    drive_b(1'b0, 8'h0, 1'b0, 1'b1);
    check("ovf2_cleared", 32'(b_ovf), 32'd0);

    // Reset mid-run with 3 words queued
    a_ready = 1'b0;
    drive_a(1'b1, 16'h0100, 1'b0, 1'b0);
    drive_a(1'b1, 16'h0200, 1'b0, 1'b0);
    drive_a(1'b1, 16'h0200, 1'b0, 1'b0);
    drive_a(1'b1, 16'h0200, 1'b0, 1'b0);
    check("mid_level", 32'(a_level), 32'd3);
    check("mid_state", 32'(a_state), 32'd2);
    rst_n = 1'b0;
    #2;
    check("mid_rst_valid", 32'(a_ovalid), 32'd0);
    check("mid_rst_level", 32'(a_level),  32'd0);
    check("mid_rst_ovf",   32'(a_ovf),    32'd0);
    check("mid_rst_state", 32'(a_state),  32'd0);
    exp_a_q.delete();
    exp_b_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    a_ready = 1'b1;
    exp_a_q.push_back(16'h0200);
    drive_a(1'b1, 16'h0200, 1'b0, 1'b0);
    check("post_rst_raw",   32'(a_out),   32'h0200);
    check("post_rst_state", 32'(a_state), 32'd1);
    idle_a(2);

    check("a_queue_empty", 32'(exp_a_q.size()), 32'd0);
    check("b_queue_empty", 32'(exp_b_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
